// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 serial receiver for the RS485 link, oversampled by OVS.
// Deserialises BYTES bytes per frame. Each byte is written into the frame RAM
// at {cycle,2'b00} + byte_index. A one-clock done pulse marks the end of the frame.
//
// Optional feature macro: RX_TIMEOUT_EN. When it is defined, a gap counter aborts
// a frame that stalls between bytes. When it is undefined, o_timeout is tied 0.
//
// Ports:
//   i_clk        sampling clock, OVS x baud
//   i_reset      asynchronous reset, active high
//   i_en         receive enable; low forces IDLE
//   i_rx         serial line, idle high, asynchronous to i_clk
//   i_cycle      frame slot number, sampled when each byte is stored
//   o_addr       RAM write address
//   o_data       RAM write data
//   o_we         one-clock write strobe
//   o_done       one-clock pulse, one clock after the last write of a frame
//   o_busy       high whenever the receiver is not idle
//   o_frame_err  sticky bad-stop-bit flag
//   o_timeout    sticky inter-byte timeout flag
module uart_frame_rx #(
  parameter int BYTES        = 4,
  parameter int OVS          = 8,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_rx,
  input  logic [5:0] i_cycle,
  output logic [8:0] o_addr,
  output logic [7:0] o_data,
  output logic       o_we,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_STORE, S_GAP, S_DONE, S_FLUSH
  } state_t;

  localparam logic [4:0] HALF_M1   = 5'(OVS/2 - 1);
  localparam logic [4:0] FULL_M1   = 5'(OVS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

  state_t     r_state;
  logic [1:0] r_sync;
  logic [4:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic [1:0] r_byte_idx;
  logic [8:0] r_addr;
  logic [7:0] r_data;
  logic       r_we;
  logic       r_done;
  logic       r_frame_err;
  logic       w_rx_s;

`ifdef RX_TIMEOUT_EN
  localparam int GAP_LIM = TIMEOUT_BITS * OVS;
  localparam int GW      = $clog2(GAP_LIM);
  logic [GW-1:0] r_gap;
  logic          r_timeout;
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  // Two-flop synchroniser. It resets to the idle-high level so that reset does not fake a start bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], i_rx};
  end
  assign w_rx_s = r_sync[1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_byte_idx  <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
      r_gap       <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (!i_en) begin
        r_state    <= S_IDLE;
        r_byte_idx <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_byte_idx <= '0;
            if (!w_rx_s) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end
          S_START: begin
            if (r_cnt == HALF_M1) begin
              r_cnt <= '0;
              if (!w_rx_s) begin
                r_state <= S_DATA;
                r_bit   <= '0;
                // The flags are cleared only when a genuine start bit opens a new frame.
                if (r_byte_idx == 2'd0) begin
                  r_frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
                  r_timeout   <= 1'b0;
`endif
                end
              end else begin
                // A glitch inside a frame returns to GAP. Any gap time already spent is forgotten.
                r_state <= (r_byte_idx == 2'd0) ? S_IDLE : S_GAP;
`ifdef RX_TIMEOUT_EN
                r_gap   <= '0;
`endif
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          S_DATA: begin
            if (r_cnt == FULL_M1) begin
              r_cnt   <= '0;
              r_shift <= {w_rx_s, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= S_STOP;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          S_STOP: begin
            if (r_cnt == FULL_M1) begin
              r_cnt <= '0;
              if (w_rx_s) begin
                // The write is issued together with the stop sample so that o_we rises on the next clock.
                r_state <= S_STORE;
                r_we    <= 1'b1;
                r_data  <= r_shift;
                r_addr  <= {1'b0, i_cycle, 2'b00} + {7'b0, r_byte_idx};
              end else begin
                r_state     <= S_FLUSH;
                r_frame_err <= 1'b1;
                r_byte_idx  <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
          S_STORE: begin
            if (r_byte_idx == LAST_BYTE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_GAP;
              r_byte_idx <= r_byte_idx + 2'd1;
`ifdef RX_TIMEOUT_EN
              r_gap      <= '0;
`endif
            end
          end
          S_GAP: begin
            if (!w_rx_s) begin
              r_state <= S_START;
              r_cnt   <= '0;
`ifdef RX_TIMEOUT_EN
            end else if (r_gap == GW'(GAP_LIM - 1)) begin
              r_state    <= S_IDLE;
              r_timeout  <= 1'b1;
              r_byte_idx <= '0;
            end else begin
              r_gap <= r_gap + 1'b1;
`endif
            end
          end
          S_DONE: begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
          end
          S_FLUSH: begin
            // The line must stay high for a full bit time before a new start bit is trusted.
            if (!w_rx_s)               r_cnt   <= '0;
            else if (r_cnt == FULL_M1) r_state <= S_IDLE;
            else                       r_cnt   <= r_cnt + 5'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_we        = r_we;
  assign o_done      = r_done;
  assign o_busy      = (r_state != S_IDLE);
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx (BYTES=4, OVS=8, TIMEOUT_BITS=16).
module tb_uart_frame_rx;
  localparam int OVS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       rx = 1'b1;
  logic [5:0] cycle = '0;
  logic [8:0] o_addr;
  logic [7:0] o_data;
  logic       o_we, o_done, o_busy, o_frame_err, o_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_we_cyc = 0;
  logic [8:0] wa[$];
  logic [7:0] wd[$];

  uart_frame_rx #(.BYTES(4), .OVS(OVS), .TIMEOUT_BITS(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_rx(rx), .i_cycle(cycle),
    .o_addr(o_addr), .o_data(o_data), .o_we(o_we), .o_done(o_done),
    .o_busy(o_busy), .o_frame_err(o_frame_err), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Record every RAM write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_we) begin
      wa.push_back(o_addr);
      wd.push_back(o_data);
      last_we_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_t(input logic v);
    rx = v;
    clocks(OVS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i]);
    bit_t(stop);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  function automatic logic [31:0] qa(input int i);
    if (i < wa.size()) return 32'(wa[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] qd(input int i);
    if (i < wd.size()) return 32'(wd[i]);
    return 'x;
  endfunction

  task automatic chk_frame(input string tag, input int n0, input logic [8:0] base,
                           input logic [7:0] b0, b1, b2, b3);
    logic [7:0] eb[4];
    eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
    chk({tag, "_nwr"}, 32'(wa.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), qa(n0 + i), 32'(base) + 32'(i));
      chk($sformatf("%s_data%0d", tag, i), qd(n0 + i), 32'(eb[i]));
    end
  endtask

  initial begin
    int n0;
    int d0;

    // Reset state
    clocks(2);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_ctl", {27'd0, o_we, o_done, o_busy, o_frame_err, o_timeout}, 32'd0);
    reset = 1'b0;
    en = 1'b1;
    clocks(4);

    // T1: basic frame at cycle 3 -> addresses 12..15
    cycle = 6'd3;
    n0 = wa.size();
    d0 = done_cnt;
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
    clocks(8);
    chk_frame("t1", n0, 9'd12, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_done_lag", 32'(done_cyc - last_we_cyc), 32'd1);
    chk("t1_flags", {30'd0, o_frame_err, o_timeout}, 32'd0);
    chk("t1_busy", 32'(o_busy), 32'd0);
    chk("t1_addr_hold", 32'(o_addr), 32'd15);

    // T2: 3-clock low glitch in IDLE
    n0 = wa.size();
    rx = 1'b0;
    clocks(3);
    rx = 1'b1;
    clocks(1);
    chk("t2_busy_start", 32'(o_busy), 32'd1);
    clocks(7);
    chk("t2_busy_idle", 32'(o_busy), 32'd0);
    chk("t2_no_we", 32'(wa.size() - n0), 32'd0);

    // T3: bad stop bit, then a valid frame clears frame_err
    n0 = wa.size();
    send_byte(8'h55, 1'b0);
    chk("t3_ferr", 32'(o_frame_err), 32'd1);
    chk("t3_flush_busy", 32'(o_busy), 32'd1);
    chk("t3_no_we", 32'(wa.size() - n0), 32'd0);
    rx = 1'b1;
    clocks(20);
    chk("t3_idle", 32'(o_busy), 32'd0);
    chk("t3_ferr_sticky", 32'(o_frame_err), 32'd1);
    cycle = 6'd5;
    n0 = wa.size();
    d0 = done_cnt;
    send_frame(8'h01, 8'h80, 8'h7E, 8'hC3);
    clocks(8);
    chk_frame("t3", n0, 9'd20, 8'h01, 8'h80, 8'h7E, 8'hC3);
    chk("t3_ferr_clr", 32'(o_frame_err), 32'd0);
    chk("t3_done", 32'(done_cnt - d0), 32'd1);

    // T4: two bytes then a long idle in GAP
    cycle = 6'd6;
    n0 = wa.size();
    d0 = done_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    clocks(120);
    chk("t4_to_early", 32'(o_timeout), 32'd0);
    chk("t4_busy_early", 32'(o_busy), 32'd1);
    clocks(16);
`ifdef RX_TIMEOUT_EN
    chk("t4_timeout", 32'(o_timeout), 32'd1);
    chk("t4_busy", 32'(o_busy), 32'd0);
`else
    chk("t4_timeout", 32'(o_timeout), 32'd0);
    chk("t4_busy", 32'(o_busy), 32'd1);
`endif
    chk("t4_nwr", 32'(wa.size() - n0), 32'd2);
    chk("t4_addr1", qa(n0 + 1), 32'd25);
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    en = 1'b0;
    clocks(2);
    en = 1'b1;
    clocks(2);
    chk("t4_idle", 32'(o_busy), 32'd0);
    cycle = 6'd7;
    n0 = wa.size();
    send_frame(8'h5A, 8'hC6, 8'h0F, 8'hF0);
    clocks(8);
    chk_frame("t4", n0, 9'd28, 8'h5A, 8'hC6, 8'h0F, 8'hF0);
    chk("t4_to_clr", 32'(o_timeout), 32'd0);

    // T5: en dropped during bit 4 of byte 1 (byte 0x6B)
    cycle = 6'd8;
    n0 = wa.size();
    d0 = done_cnt;
    send_byte(8'h9A, 1'b1);
    bit_t(1'b0);
    bit_t(1'b1); bit_t(1'b1); bit_t(1'b0); bit_t(1'b1);
    rx = 1'b0;
    clocks(2);
    en = 1'b0;
    clocks(1);
    chk("t5_idle", 32'(o_busy), 32'd0);
    rx = 1'b1;
    clocks(3);
    chk("t5_nwr", 32'(wa.size() - n0), 32'd1);
    chk("t5_addr0", qa(n0), 32'd32);
    chk("t5_data0", qd(n0), 32'h9A);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    en = 1'b1;
    clocks(6);
    cycle = 6'd9;
    n0 = wa.size();
    send_frame(8'h12, 8'h34, 8'h56, 8'h78);
    clocks(8);
    chk_frame("t5", n0, 9'd36, 8'h12, 8'h34, 8'h56, 8'h78);

    // T6: reset during DATA of byte 2
    cycle = 6'd10;
    n0 = wa.size();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    bit_t(1'b0);
    bit_t(1'b1); bit_t(1'b0);
    rx = 1'b1;
    clocks(3);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_addr", 32'(o_addr), 32'd0);
    chk("t6_rst_data", 32'(o_data), 32'd0);
    chk("t6_rst_ctl", {27'd0, o_we, o_done, o_busy, o_frame_err, o_timeout}, 32'd0);
    clocks(1);
    reset = 1'b0;
    rx = 1'b1;
    clocks(4);
    chk("t6_nwr_pre", 32'(wa.size() - n0), 32'd2);
    chk("t6_addr_pre", qa(n0 + 1), 32'd41);
    cycle = 6'd11;
    n0 = wa.size();
    d0 = done_cnt;
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    clocks(8);
    chk_frame("t6", n0, 9'd44, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    chk("t6_done", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
